// File: rtl/oflow_cr_pkg.sv
// Shared widths, types and state encoding for the score-board conflict resolver.
package oflow_cr_pkg;

    localparam int MAX_ROWS  = 32;
    localparam int ROW_LEN   = 5;
    localparam int SCORE_LEN = 16;
    localparam int ID_LEN    = 12;

    typedef logic [ROW_LEN-1:0]   row_t;
    typedef logic [ROW_LEN:0]     cnt_t;
    typedef logic [SCORE_LEN-1:0] score_t;
    typedef logic [ID_LEN-1:0]    id_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_I = 3'd1,
        SCAN   = 3'd2,
        WRITE  = 3'd3,
        DONE   = 3'd4
    } cr_state_e;

    localparam cnt_t CNT_ONE = {{ROW_LEN{1'b0}}, 1'b1};
    localparam cnt_t CNT_MAX = {(ROW_LEN+1){1'b1}};

    function automatic cnt_t sat_inc(input cnt_t v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

endpackage

// File: rtl/oflow_cr_compare.sv
// Pairwise conflict test: equal selected IDs conflict; the larger score loses, ties go against row b.
module oflow_cr_compare
    import oflow_cr_pkg::*;
(
    input  logic [SCORE_LEN-1:0] score_a_i,
    input  logic [SCORE_LEN-1:0] score_b_i,
    input  logic [ID_LEN-1:0]    id_a_i,
    input  logic [ID_LEN-1:0]    id_b_i,
    input  logic [ROW_LEN-1:0]   row_a_i,
    input  logic [ROW_LEN-1:0]   row_b_i,
    output logic                 conflict_o,
    output logic [ROW_LEN-1:0]   loser_row_o
);

    // Row b is always the higher index, so it takes the loss on equal scores.
    always_comb begin
        conflict_o  = (id_a_i == id_b_i);
        loser_row_o = (score_a_i > score_b_i) ? row_a_i : row_b_i;
    end

endmodule

// File: rtl/oflow_conflict_resolve.sv
// Scans valid score-board rows pairwise, flipping the pointer of the worse row in each ID conflict
// and restarting the pass after every write until a write-free pass completes.
module oflow_conflict_resolve
    import oflow_cr_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start_cr,
    input  logic [ROW_LEN:0]     num_rows,
    input  logic                 ready_new_frame,
    output logic [ROW_LEN-1:0]   row_sel_from_cr,
    input  logic [SCORE_LEN-1:0] score_to_cr,
    input  logic [ID_LEN-1:0]    id_to_cr,
    output logic                 write_to_pointer,
    output logic [ROW_LEN-1:0]   row_to_change,
    output logic                 data_from_cr,
    output logic                 busy,
    output logic                 done_cr,
    output logic [ROW_LEN:0]     unresolved_cnt
);

    cr_state_e           state_q, state_d;
    cnt_t                i_q, i_d, j_q, j_d, n_q, n_d, unres_q, unres_d;
    score_t              score_i_q, score_i_d;
    id_t                 id_i_q, id_i_d;
    logic [MAX_ROWS-1:0] shadow_q, shadow_d;
    row_t                loser_q, loser_d, row_sel_q, row_sel_d;
    logic                write_q, busy_q, done_q;
    logic                conflict_s;
    row_t                loser_s;

    oflow_cr_compare u_cmp (
        .score_a_i   (score_i_q),
        .score_b_i   (score_to_cr),
        .id_a_i      (id_i_q),
        .id_b_i      (id_to_cr),
        .row_a_i     (i_q[ROW_LEN-1:0]),
        .row_b_i     (j_q[ROW_LEN-1:0]),
        .conflict_o  (conflict_s),
        .loser_row_o (loser_s)
    );

    // Next-state, scan indices, shadow pointers and read-row selection.
    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        j_d       = j_q;
        n_d       = n_q;
        score_i_d = score_i_q;
        id_i_d    = id_i_q;
        shadow_d  = shadow_q;
        unres_d   = unres_q;
        loser_d   = loser_q;
        case (state_q)
            IDLE: begin
                if (start_cr) begin
                    n_d      = num_rows;
                    shadow_d = '0;
                    unres_d  = '0;
                    i_d      = '0;
                    state_d  = (num_rows <= CNT_ONE) ? DONE : LOAD_I;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD_I: begin
                score_i_d = score_to_cr;
                id_i_d    = id_to_cr;
                j_d       = i_q + CNT_ONE;
                state_d   = SCAN;
            end
            SCAN: begin
                if (conflict_s && !shadow_q[loser_s]) begin
                    loser_d = loser_s;
                    state_d = WRITE;
                end else begin
                    if (conflict_s) begin
                        unres_d = sat_inc(unres_q);
                    end else begin
                        unres_d = unres_q;
                    end
                    // Last j for this i: advance i, or finish once no pair remains.
                    if (j_q == n_q - CNT_ONE) begin
                        i_d     = i_q + CNT_ONE;
                        state_d = ((i_q + CNT_ONE) == (n_q - CNT_ONE)) ? DONE : LOAD_I;
                    end else begin
                        j_d     = j_q + CNT_ONE;
                        state_d = SCAN;
                    end
                end
            end
            WRITE: begin
                shadow_d[loser_q] = 1'b1;
                unres_d           = '0;
                i_d               = '0;
                state_d           = LOAD_I;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_d == LOAD_I) begin
            row_sel_d = i_d[ROW_LEN-1:0];
        end else if (state_d == SCAN) begin
            row_sel_d = j_d[ROW_LEN-1:0];
        end else begin
            row_sel_d = row_sel_q;
        end
    end

    // State and registered outputs; a new-frame abort clears everything like reset.
    always_ff @(posedge clk) begin
        if (reset || ready_new_frame) begin
            state_q   <= IDLE;
            i_q       <= '0;
            j_q       <= '0;
            n_q       <= '0;
            score_i_q <= '0;
            id_i_q    <= '0;
            shadow_q  <= '0;
            unres_q   <= '0;
            loser_q   <= '0;
            row_sel_q <= '0;
            write_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            i_q       <= i_d;
            j_q       <= j_d;
            n_q       <= n_d;
            score_i_q <= score_i_d;
            id_i_q    <= id_i_d;
            shadow_q  <= shadow_d;
            unres_q   <= unres_d;
            loser_q   <= loser_d;
            row_sel_q <= row_sel_d;
            write_q   <= (state_d == WRITE);
            busy_q    <= (state_d != IDLE);
            done_q    <= (state_d == DONE);
        end
    end

    assign row_sel_from_cr  = row_sel_q;
    assign write_to_pointer = write_q;
    assign row_to_change    = loser_q;
    assign data_from_cr     = write_q;
    assign busy             = busy_q;
    assign done_cr          = done_q;
    assign unresolved_cnt   = unres_q;

endmodule

// File: tb/tb_oflow_conflict_resolve.sv
// Directed bench: a two-candidate score-board model feeds the resolver; each task checks one scenario.
module tb_oflow_conflict_resolve;

    logic        clk = 1'b0;
    logic        reset, start_cr, ready_new_frame;
    logic [5:0]  num_rows;
    logic [4:0]  row_sel_from_cr, row_to_change;
    logic [15:0] score_to_cr;
    logic [11:0] id_to_cr;
    logic        write_to_pointer, data_from_cr, busy, done_cr;
    logic [5:0]  unresolved_cnt;

    logic [11:0] c0_id [32];
    logic [11:0] c1_id [32];
    logic [15:0] c0_s  [32];
    logic [15:0] c1_s  [32];
    logic        ptr   [32];

    int n_total = 0;
    int n_bad   = 0;
    int wr_rows [$];
    int wr_data_bad = 0;
    int done_pulses = 0;
    int lat;

    always #5 clk = ~clk;

    oflow_conflict_resolve dut (
        .clk              (clk),
        .reset            (reset),
        .start_cr         (start_cr),
        .num_rows         (num_rows),
        .ready_new_frame  (ready_new_frame),
        .row_sel_from_cr  (row_sel_from_cr),
        .score_to_cr      (score_to_cr),
        .id_to_cr         (id_to_cr),
        .write_to_pointer (write_to_pointer),
        .row_to_change    (row_to_change),
        .data_from_cr     (data_from_cr),
        .busy             (busy),
        .done_cr          (done_cr),
        .unresolved_cnt   (unresolved_cnt)
    );

    assign id_to_cr    = ptr[row_sel_from_cr] ? c1_id[row_sel_from_cr] : c0_id[row_sel_from_cr];
    assign score_to_cr = ptr[row_sel_from_cr] ? c1_s[row_sel_from_cr]  : c0_s[row_sel_from_cr];

    // Score-board pointer update and event log.
    always @(negedge clk) begin
        if (write_to_pointer === 1'b1) begin
            wr_rows.push_back(int'(row_to_change));
            if (data_from_cr !== 1'b1) wr_data_bad++;
            ptr[row_to_change] = data_from_cr;
        end
        if (done_cr === 1'b1) done_pulses++;
    end

    task automatic clear_board();
        for (int r = 0; r < 32; r++) begin
            c0_id[r] = 12'(100 + r);
            c1_id[r] = 12'(200 + r);
            c0_s[r]  = 16'd0;
            c1_s[r]  = 16'd0;
            ptr[r]   = 1'b0;
        end
    endtask

    task automatic set_row(input int r, input int id0, input int s0, input int id1, input int s1);
        c0_id[r] = 12'(id0);
        c0_s[r]  = 16'(s0);
        c1_id[r] = 12'(id1);
        c1_s[r]  = 16'(s1);
    endtask

    task automatic run_cr(input int n, input int limit, output int l);
        wr_rows.delete();
        wr_data_bad = 0;
        done_pulses = 0;
        @(negedge clk);
        num_rows = 6'(n);
        start_cr = 1'b1;
        @(negedge clk);
        start_cr = 1'b0;
        l = 1;
        while (done_cr !== 1'b1 && l < limit) begin
            @(negedge clk);
            l++;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; start_cr = 1'b0; ready_new_frame = 1'b0; num_rows = 6'd0;
        clear_board();
        repeat (3) @(negedge clk);
        n_total++;
        if ({busy, done_cr, write_to_pointer, data_from_cr} !== 4'b0000) begin
            n_bad++; $display("FAIL reset_flags got=%b want=0000", {busy, done_cr, write_to_pointer, data_from_cr});
        end
        n_total++;
        if ({row_sel_from_cr, row_to_change, unresolved_cnt} !== 16'd0) begin
            n_bad++; $display("FAIL reset_fields got=%h want=0", {row_sel_from_cr, row_to_change, unresolved_cnt});
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_no_conflict();
        clear_board();
        set_row(0, 5, 1, 50, 1); set_row(1, 6, 2, 51, 1);
        set_row(2, 7, 3, 52, 1); set_row(3, 8, 4, 53, 1);
        run_cr(4, 200, lat);
        n_total++;
        if (lat !== 10) begin n_bad++; $display("FAIL n4_latency got=%0d want=10", lat); end
        n_total++;
        if (wr_rows.size() !== 0) begin n_bad++; $display("FAIL n4_writes got=%0d want=0", wr_rows.size()); end
        n_total++;
        if (unresolved_cnt !== 6'd0) begin n_bad++; $display("FAIL n4_unres got=%0d want=0", unresolved_cnt); end
        n_total++;
        if (done_pulses !== 1) begin n_bad++; $display("FAIL n4_done_pulses got=%0d want=1", done_pulses); end
        n_total++;
        if (busy !== 1'b0 || row_sel_from_cr !== 5'd3) begin
            n_bad++; $display("FAIL n4_idle_hold got busy=%b row=%0d want busy=0 row=3", busy, row_sel_from_cr);
        end
    endtask

    task automatic test_chain_writes();
        clear_board();
        set_row(0, 5, 10, 60, 1);
        set_row(1, 5, 20, 9, 25);
        set_row(2, 9, 30, 11, 40);
        run_cr(3, 200, lat);
        n_total++;
        if (lat !== 15) begin n_bad++; $display("FAIL chain_latency got=%0d want=15", lat); end
        n_total++;
        if (wr_rows.size() !== 2) begin
            n_bad++; $display("FAIL chain_nwrites got=%0d want=2", wr_rows.size());
        end else if (wr_rows[0] !== 1 || wr_rows[1] !== 2) begin
            n_bad++; $display("FAIL chain_rows got=%0d,%0d want=1,2", wr_rows[0], wr_rows[1]);
        end
        n_total++;
        if (wr_data_bad !== 0) begin n_bad++; $display("FAIL chain_data got=%0d bad strobes want=0", wr_data_bad); end
        n_total++;
        if (unresolved_cnt !== 6'd0) begin n_bad++; $display("FAIL chain_unres got=%0d want=0", unresolved_cnt); end
    endtask

    task automatic test_equal_scores();
        clear_board();
        set_row(0, 3, 15, 70, 1);
        set_row(1, 4, 1, 71, 1);
        set_row(2, 3, 15, 7, 2);
        run_cr(3, 200, lat);
        n_total++;
        if (lat !== 10) begin n_bad++; $display("FAIL tie_latency got=%0d want=10", lat); end
        n_total++;
        if (wr_rows.size() !== 1) begin
            n_bad++; $display("FAIL tie_nwrites got=%0d want=1", wr_rows.size());
        end else if (wr_rows[0] !== 2) begin
            n_bad++; $display("FAIL tie_row got=%0d want=2", wr_rows[0]);
        end
    endtask

    task automatic test_unresolved();
        clear_board();
        set_row(0, 5, 10, 80, 1);
        set_row(1, 5, 20, 5, 30);
        run_cr(2, 200, lat);
        n_total++;
        if (lat !== 6) begin n_bad++; $display("FAIL unres_latency got=%0d want=6", lat); end
        n_total++;
        if (wr_rows.size() !== 1) begin
            n_bad++; $display("FAIL unres_nwrites got=%0d want=1", wr_rows.size());
        end else if (wr_rows[0] !== 1) begin
            n_bad++; $display("FAIL unres_row got=%0d want=1", wr_rows[0]);
        end
        repeat (3) @(negedge clk);
        n_total++;
        if (unresolved_cnt !== 6'd1) begin n_bad++; $display("FAIL unres_cnt got=%0d want=1", unresolved_cnt); end
    endtask

    task automatic test_small_n();
        for (int n = 0; n < 2; n++) begin
            clear_board();
            run_cr(n, 50, lat);
            n_total++;
            if (lat !== 1) begin n_bad++; $display("FAIL small_latency n=%0d got=%0d want=1", n, lat); end
            n_total++;
            if (wr_rows.size() !== 0 || done_pulses !== 1) begin
                n_bad++; $display("FAIL small_events n=%0d got writes=%0d dones=%0d want 0/1", n, wr_rows.size(), done_pulses);
            end
        end
    endtask

    task automatic test_abort();
        clear_board();
        set_row(0, 5, 10, 80, 1);
        set_row(1, 5, 20, 5, 30);
        done_pulses = 0;
        @(negedge clk);
        num_rows = 6'd2; start_cr = 1'b1;
        @(negedge clk);
        start_cr = 1'b0;
        repeat (4) @(negedge clk);
        ready_new_frame = 1'b1;
        @(negedge clk);
        ready_new_frame = 1'b0;
        n_total++;
        if (busy !== 1'b0 || done_cr !== 1'b0 || unresolved_cnt !== 6'd0) begin
            n_bad++; $display("FAIL abort_state got busy=%b done=%b unres=%0d want 0/0/0", busy, done_cr, unresolved_cnt);
        end
        repeat (10) @(negedge clk);
        n_total++;
        if (done_pulses !== 0) begin n_bad++; $display("FAIL abort_no_done got=%0d want=0", done_pulses); end
        for (int r = 0; r < 32; r++) ptr[r] = 1'b0;
        run_cr(2, 200, lat);
        n_total++;
        if (lat !== 6 || wr_rows.size() !== 1 || unresolved_cnt !== 6'd1) begin
            n_bad++; $display("FAIL abort_rerun got lat=%0d writes=%0d unres=%0d want 6/1/1", lat, wr_rows.size(), unresolved_cnt);
        end
    endtask

    task automatic test_start_while_busy();
        int l;
        clear_board();
        set_row(0, 5, 1, 50, 1); set_row(1, 6, 2, 51, 1);
        set_row(2, 7, 3, 52, 1); set_row(3, 8, 4, 53, 1);
        done_pulses = 0;
        @(negedge clk);
        num_rows = 6'd4; start_cr = 1'b1;
        @(negedge clk);
        start_cr = 1'b0;
        l = 1;
        while (done_cr !== 1'b1 && l < 200) begin
            if (l == 2) begin start_cr = 1'b1; num_rows = 6'd2; end
            else start_cr = 1'b0;
            @(negedge clk);
            l++;
        end
        start_cr = 1'b1;
        @(negedge clk);
        start_cr = 1'b0;
        n_total++;
        if (l !== 10) begin n_bad++; $display("FAIL busy_start_latency got=%0d want=10", l); end
        n_total++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL done_cycle_start got busy=%b want=0", busy); end
        repeat (3) @(negedge clk);
        n_total++;
        if (done_pulses !== 1) begin n_bad++; $display("FAIL busy_start_dones got=%0d want=1", done_pulses); end
    endtask

    initial begin
        test_reset();
        test_no_conflict();
        test_chain_writes();
        test_equal_scores();
        test_unresolved();
        test_small_n();
        test_abort();
        test_start_while_busy();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
